instruction_fetch_unit: RTL
===========================

# instruction_fetch_unit

Fetch stage of the soft MIPS core. Holds the program counter, drives the word address into the 32-entry instruction memory, and registers the returned 32-bit word into the IF/ID pipeline register. Handles stall, flush, branch and jump redirection, a start/halt run-control FSM, and a saturating fetch counter. The instruction memory is combinational and sits between this block's address output and its instruction input.

## Interface
- ADDR_WIDTH, 5, word-address width (32-word memory)
- DATA_WIDTH, 32, instruction width
- RESET_PC, 0, PC value after reset and on restart
- HALT_WORD, 32'h0000000D, encoding that halts fetch (MIPS `break`)
- COUNT_WIDTH, 16, fetch counter width

Ports:
- Clk  in  1  rising-edge clock
- Reset  in  1  asynchronous, active-high; the only clock is Clk
- Start  in  1  leave IDLE/HALT and begin fetching at RESET_PC
- Stall  in  1  hold PC and IF/ID contents
- Flush  in  1  invalidate IF/ID at next edge
- Branch_Taken  in  1  redirect PC to Branch_Target
- Branch_Target  in  ADDR_WIDTH  branch word address
- Jump  in  1  redirect PC to Jump_Target
- Jump_Target  in  ADDR_WIDTH  jump word address (low bits of 26-bit field)
- Instruction  in  DATA_WIDTH  word returned by instruction memory
- Instruction_Address  out  ADDR_WIDTH  current PC to instruction memory
- IFID_Instruction  out  DATA_WIDTH  registered instruction
- IFID_PC_Plus1  out  ADDR_WIDTH  registered PC+1 of that instruction
- IFID_Valid  out  1  IF/ID holds a real instruction
- Running  out  1  FSM in RUN
- Halted  out  1  FSM in HALT
- Fetch_Count  out  COUNT_WIDTH  valid instructions delivered, saturating

## Operation
- FSM states: IDLE, RUN, HALT. Reset -> IDLE.
- IDLE: PC = RESET_PC, IFID_Valid = 0. Start -> RUN.
- RUN, each edge, priority highest first:
  1. Branch_Taken: PC <- Branch_Target; IFID_Valid <- 0 (wrong-path word discarded).
  2. Jump: PC <- Jump_Target; IFID_Valid <- 0.
  3. Flush (no redirect): IFID_Valid <- 0; PC advances per rules 4-6.
  4. Stall: PC, IFID_* held unchanged.
  5. Instruction == HALT_WORD: PC held, IFID_Valid <- 0, state -> HALT; halt word never delivered.
  6. Otherwise: IFID_Instruction <- Instruction, IFID_PC_Plus1 <- PC+1, IFID_Valid <- 1, PC <- PC+1.
- Branch_Taken and Jump together: branch wins (older instruction). Redirect beats Stall and Flush.
- Stall with Flush (no redirect): IFID_Valid <- 0, PC held.
- PC+1 is modulo 2^ADDR_WIDTH: 31 -> 0, no flag.
- HALT: PC held, IFID_Valid = 0; redirects, Stall, Flush ignored. Start -> PC <- RESET_PC, state RUN.
- IDLE/HALT: Branch_Taken, Jump, Stall, Flush ignored.
- Fetch_Count increments by 1 on every edge that loads IFID_Valid <- 1; saturates at all-ones; cleared only by Reset.

## Timing
- Reset (async, any cycle incl. mid-redirect): immediately PC = RESET_PC, IFID_Instruction = 0, IFID_PC_Plus1 = 0, IFID_Valid = 0, Fetch_Count = 0, Running = 0, Halted = 0, state IDLE.
- Instruction_Address = PC, combinational from the PC register; Instruction is sampled the same cycle.
- Fetch latency: word at address A appears on IFID_* one edge after PC = A.
- Start sampled at edge n -> Running = 1 after edge n; first valid IF/ID after edge n+1.
- Redirect sampled at edge n -> Instruction_Address = target after edge n; target instruction valid in IF/ID after edge n+1 (one bubble).
- Halt word at PC sampled at edge n -> Halted = 1, Running = 0 after edge n.
- Running, Halted registered outputs decoded from state.

## Test plan
- Reset, Start, memory 0..3 = distinct words, no HALT_WORD -> IFID_Instruction follows words 0,1,2,3 on consecutive edges, IFID_PC_Plus1 = 1,2,3,4, Fetch_Count = 4.
- Stall held 3 cycles at PC = 2 -> Instruction_Address stays 2, IFID_* unchanged, Fetch_Count unchanged; resumes with word 2 delivered.
- Branch_Taken = 1, Branch_Target = 25 with Jump = 1, Jump_Target = 7, Stall = 1 same cycle -> PC = 25, one bubble (IFID_Valid = 0), then word 25 with IFID_PC_Plus1 = 26.
- Run from PC = 30 with no halt -> addresses 30, 31, 0; IFID_PC_Plus1 for word 31 = 0.
- HALT_WORD at address 5 -> words 0..4 delivered, Halted = 1, PC stays 5, IFID_Valid = 0; Start -> restart from 0, Fetch_Count continues from 5.
- Assert Reset asynchronously mid-redirect -> all outputs zero before next edge, state IDLE, Start required to fetch.

Source files
------------

// File: rtl/instruction_fetch_unit.sv
// Fetch stage: program counter, IF/ID pipeline register, start/halt run control
// and a saturating count of delivered instructions.
//
// state  | meaning
// IDLE   | after reset; PC parked at RESET_PC, waiting for Start
// RUN    | fetching one word per edge, honouring redirect/flush/stall
// HALT   | halt word seen; PC frozen until Start restarts at RESET_PC
module instruction_fetch_unit #(
    parameter int                        ADDR_WIDTH  = 5,
    parameter int                        DATA_WIDTH  = 32,
    parameter logic [ADDR_WIDTH-1:0]     RESET_PC    = '0,
    parameter logic [DATA_WIDTH-1:0]     HALT_WORD   = 32'h0000000D,
    parameter int                        COUNT_WIDTH = 16
) (
    input  logic                   Clk,
    input  logic                   Reset,
    input  logic                   Start,
    input  logic                   Stall,
    input  logic                   Flush,
    input  logic                   Branch_Taken,
    input  logic [ADDR_WIDTH-1:0]  Branch_Target,
    input  logic                   Jump,
    input  logic [ADDR_WIDTH-1:0]  Jump_Target,
    input  logic [DATA_WIDTH-1:0]  Instruction,
    output logic [ADDR_WIDTH-1:0]  Instruction_Address,
    output logic [DATA_WIDTH-1:0]  IFID_Instruction,
    output logic [ADDR_WIDTH-1:0]  IFID_PC_Plus1,
    output logic                   IFID_Valid,
    output logic                   Running,
    output logic                   Halted,
    output logic [COUNT_WIDTH-1:0] Fetch_Count
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_HALT} state_t;

    state_t                state;
    logic [ADDR_WIDTH-1:0] pc;
    logic [ADDR_WIDTH-1:0] pc_plus1;
    logic                  is_halt;

    // PC+1 wraps modulo 2^ADDR_WIDTH without any flag
    assign pc_plus1            = pc + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
    assign is_halt             = (Instruction == HALT_WORD);
    assign Instruction_Address = pc;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state            <= S_IDLE;
            pc               <= RESET_PC;
            IFID_Instruction <= '0;
            IFID_PC_Plus1    <= '0;
            IFID_Valid       <= 1'b0;
            Running          <= 1'b0;
            Halted           <= 1'b0;
            Fetch_Count      <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    pc         <= RESET_PC;
                    IFID_Valid <= 1'b0;
                    if (Start) begin
                        state   <= S_RUN;
                        Running <= 1'b1;
                        Halted  <= 1'b0;
                    end
                end
                S_RUN: begin
                    if (Branch_Taken) begin
                        pc         <= Branch_Target;
                        IFID_Valid <= 1'b0;
                    end else if (Jump) begin
                        pc         <= Jump_Target;
                        IFID_Valid <= 1'b0;
                    end else if (Flush) begin
                        // Bubble the IF/ID slot but let the PC follow stall/halt/advance
                        IFID_Valid <= 1'b0;
                        if (!Stall) begin
                            if (is_halt) begin
                                state   <= S_HALT;
                                Running <= 1'b0;
                                Halted  <= 1'b1;
                            end else begin
                                pc <= pc_plus1;
                            end
                        end
                    end else if (Stall) begin
                        pc <= pc;
                    end else if (is_halt) begin
                        IFID_Valid <= 1'b0;
                        state      <= S_HALT;
                        Running    <= 1'b0;
                        Halted     <= 1'b1;
                    end else begin
                        IFID_Instruction <= Instruction;
                        IFID_PC_Plus1    <= pc_plus1;
                        IFID_Valid       <= 1'b1;
                        pc               <= pc_plus1;
                        if (Fetch_Count != {COUNT_WIDTH{1'b1}})
                            Fetch_Count <= Fetch_Count + 1'b1;
                    end
                end
                S_HALT: begin
                    IFID_Valid <= 1'b0;
                    if (Start) begin
                        pc      <= RESET_PC;
                        state   <= S_RUN;
                        Running <= 1'b1;
                        Halted  <= 1'b0;
                    end
                end
                default: begin
                    state      <= S_IDLE;
                    pc         <= RESET_PC;
                    IFID_Valid <= 1'b0;
                    Running    <= 1'b0;
                    Halted     <= 1'b0;
                end
            endcase
        end
    end

endmodule
